alu_driver: RTL and testbench

- Initiator side of the registered 4-bit ALU.
- Accepts tagged commands on a valid/ready stream and buffers them in a small FIFO.
- Issues commands one at a time to the ALU's operand/select pins and waits out the ALU's register latency.
- Captures the result and the carry flag, adds divide-by-zero detection, and returns a tagged response on a valid/ready stream with backpressure.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_cmd_fifo.sv | 71 +++++++
 rtl/alu_driver.sv | 183 ++++++++++++++++++
 tb/tb_alu_driver.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU initiator: op encodings, FSM states and the
// divide-by-zero substitute result.
package alu_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] ALU_ADD = 2'b00;
  localparam logic [SEL_W-1:0] ALU_SUB = 2'b01;
  localparam logic [SEL_W-1:0] ALU_MUL = 2'b10;
  localparam logic [SEL_W-1:0] ALU_DIV = 2'b11;

  // Wide enough for any practical WIDTH; users slice the low bits.
  localparam logic [31:0] DZ_RESULT = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } drv_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO for the ALU driver; each entry carries operands, select and tag.
// Full/empty come from an occupancy count one bit wider than the pointers.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [SEL_W-1:0] i_sel,
  input  logic [TAG_W-1:0] i_tag,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic [SEL_W-1:0] o_sel,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = 2 * WIDTH + SEL_W + TAG_W;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;

  logic w_push;
  logic w_pop;

  // A push is refused when full even if a pop happens in the same cycle.
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
  assign o_empty = (r_count == '0);

  assign {o_a, o_b, o_sel, o_tag} = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_a, i_b, i_sel, i_tag};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_driver.sv
// Initiator for the registered ALU: queues tagged commands, issues one at a
// time, waits out the ALU latency and returns a tagged response with dz check.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic [SEL_W-1:0] i_cmd_sel,
  input  logic [TAG_W-1:0] i_cmd_tag,
  output logic             o_alu_rst,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [SEL_W-1:0] o_alu_sel,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic             i_alu_overflow,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_ovf,
  output logic             o_rsp_dz,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_busy,
  output logic [1:0]       o_dbg_state
);

  // Both streams: a transfer happens on the rising edge where valid & ready
  // are high; a raised valid holds its payload stable until that edge.

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  drv_state_t       r_state;
  drv_state_t       w_next_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_alu_rst;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;
  logic [TAG_W-1:0] r_cur_tag;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_ovf;
  logic             r_rsp_dz;
  logic [TAG_W-1:0] r_rsp_tag;

  logic             w_pop;
  logic             w_capture;
  logic             w_resp_done;
  logic             w_is_dz;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [WIDTH-1:0] w_fifo_a;
  logic [WIDTH-1:0] w_fifo_b;
  logic [SEL_W-1:0] w_fifo_sel;
  logic [TAG_W-1:0] w_fifo_tag;

  assign o_cmd_ready = reset & ~w_fifo_full;

  alu_cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (i_cmd_valid & o_cmd_ready),
    .i_pop   (w_pop),
    .i_a     (i_cmd_a),
    .i_b     (i_cmd_b),
    .i_sel   (i_cmd_sel),
    .i_tag   (i_cmd_tag),
    .o_a     (w_fifo_a),
    .o_b     (w_fifo_b),
    .o_sel   (w_fifo_sel),
    .o_tag   (w_fifo_tag),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_is_dz = (r_alu_sel == ALU_DIV) && (r_alu_b == '0);

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_resp_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty && !r_alu_rst) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_capture    = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          w_resp_done = 1'b1;
          if (!w_fifo_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_ISSUE;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_alu_rst   <= 1'b1;
      r_wait_cnt  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_cur_tag   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_ovf   <= 1'b0;
      r_rsp_dz    <= 1'b0;
      r_rsp_tag   <= '0;
    end else begin
      // Keeps the ALU cleared for one cycle past reset release.
      r_alu_rst <= 1'b0;
      if (w_pop) begin
        r_alu_a   <= w_fifo_a;
        r_alu_b   <= w_fifo_b;
        r_alu_sel <= w_fifo_sel;
        r_cur_tag <= w_fifo_tag;
      end
      if (r_state == ST_ISSUE) begin
        r_wait_cnt <= CNT_W'(ALU_LAT - 1);
      end else if (r_state == ST_WAIT && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
      end
      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_tag   <= r_cur_tag;
        r_rsp_dz    <= w_is_dz;
        r_rsp_data  <= w_is_dz ? DZ_RESULT[WIDTH-1:0] : i_alu_out;
        r_rsp_ovf   <= i_alu_overflow & (r_alu_sel == ALU_ADD);
      end else if (w_resp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign o_alu_rst   = r_alu_rst;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_alu_sel   = r_alu_sel;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_ovf   = r_rsp_ovf;
  assign o_rsp_dz    = r_rsp_dz;
  assign o_rsp_tag   = r_rsp_tag;
  assign o_busy      = (r_state != ST_IDLE) | ~w_fifo_empty;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver with a behavioural 4-bit registered ALU attached and a
// scoreboard fed from an arithmetic reference of each accepted command.
module tb_alu_driver;

  localparam int W     = 4;
  localparam int TAG_W = 2;
  localparam int EXP_W = W + 2 + TAG_W;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic [1:0]       cmd_sel;
  logic [TAG_W-1:0] cmd_tag;
  logic             alu_rst;
  logic [W-1:0]     alu_a;
  logic [W-1:0]     alu_b;
  logic [1:0]       alu_sel;
  logic [W-1:0]     alu_out;
  logic             alu_overflow;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic             rsp_ovf;
  logic             rsp_dz;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic [1:0]       dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic rnd_done;

  alu_driver dut (
    .clk            (clk),
    .reset          (reset),
    .i_cmd_valid    (cmd_valid),
    .o_cmd_ready    (cmd_ready),
    .i_cmd_a        (cmd_a),
    .i_cmd_b        (cmd_b),
    .i_cmd_sel      (cmd_sel),
    .i_cmd_tag      (cmd_tag),
    .o_alu_rst      (alu_rst),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_sel      (alu_sel),
    .i_alu_out      (alu_out),
    .i_alu_overflow (alu_overflow),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_data     (rsp_data),
    .o_rsp_ovf      (rsp_ovf),
    .o_rsp_dz       (rsp_dz),
    .o_rsp_tag      (rsp_tag),
    .o_busy         (busy),
    .o_dbg_state    (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural registered ALU; divide by zero yields 0 so a missing
  // substitution in the driver is visible.
  always @(posedge clk) begin
    if (alu_rst) alu_out <= '0;
    else begin
      case (alu_sel)
        2'b00:   alu_out <= W'((int'(alu_a) + int'(alu_b)) % 16);
        2'b01:   alu_out <= W'((int'(alu_a) - int'(alu_b) + 16) % 16);
        2'b10:   alu_out <= W'((int'(alu_a) * int'(alu_b)) % 16);
        default: alu_out <= (alu_b == 0) ? W'(0) : W'(int'(alu_a) / int'(alu_b));
      endcase
    end
  end
  assign alu_overflow = (int'(alu_a) + int'(alu_b)) > 15;

  function automatic logic [EXP_W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] sel, input logic [TAG_W-1:0] tag);
    int r;
    logic ovf;
    logic dz;
    ovf = 1'b0;
    dz  = 1'b0;
    case (sel)
      2'b00: begin r = int'(a) + int'(b); ovf = (r >= 16); r = r % 16; end
      2'b01: r = (int'(a) - int'(b) + 16) % 16;
      2'b10: r = (int'(a) * int'(b)) % 16;
      default: begin
        if (b == 0) begin r = 15; dz = 1'b1; end
        else r = int'(a) / int'(b);
      end
    endcase
    return {W'(r), ovf, dz, tag};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic push_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] sel, input logic [TAG_W-1:0] tag);
    int guard;
    guard = 0;
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_tag = tag; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for tag %0d", tag);
      cmd_valid = 1'b0;
    end else begin
      exp_q.push_back(model(a, b, sel, tag));
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses missing", exp_q.size());
      exp_q.delete();
    end
  endtask

  // scoreboard monitor
  logic [EXP_W-1:0] cur_rsp;
  logic [EXP_W-1:0] hold_val;
  logic             hold_v;
  assign cur_rsp = {rsp_data, rsp_ovf, rsp_dz, rsp_tag};

  always @(negedge clk) begin
    if (!reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) check("rsp_hold", {rsp_valid, cur_rsp}, {1'b1, hold_val});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got %0h expected none", cur_rsp);
        end else begin
          check("rsp", cur_rsp, exp_q.pop_front());
        end
      end
      hold_v   = rsp_valid && !rsp_ready;
      hold_val = cur_rsp;
    end
  end

  initial begin
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_tag = '0;
    rsp_ready = 1'b1;
    reset = 1'b0;
    rnd_done = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_alu_rst", alu_rst, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_regs", {alu_a, alu_b, alu_sel}, 0);
    check("rst_rsp_regs", {rsp_data, rsp_tag, rsp_ovf, rsp_dz}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rel_alu_rst_hold", alu_rst, 1);
    check("rel_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    check("rel_alu_rst_clear", alu_rst, 0);

    // add with carry and first-response latency
    push_cmd(4'd9, 4'd8, 2'b00, 2'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("latency_valid", rsp_valid, (i == 3) ? 1 : 0);
    end
    drain();

    // divide by zero then wrapping subtract
    push_cmd(4'd7, 4'd0, 2'b11, 2'd2);
    push_cmd(4'd2, 4'd5, 2'b01, 2'd3);
    drain();

    // backpressure fills FIFO plus the in-flight slot
    @(posedge clk); #1 rsp_ready = 1'b0;
    push_cmd(4'd15, 4'd1, 2'b00, 2'd0);
    push_cmd(4'd3, 4'd6, 2'b10, 2'd1);
    push_cmd(4'd0, 4'd1, 2'b01, 2'd2);
    push_cmd(4'd13, 4'd4, 2'b11, 2'd3);
    push_cmd(4'd5, 4'd5, 2'b00, 2'd0);
    repeat (3) @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    // push and pop on the same edge at count DEPTH-1
    @(posedge clk); #1 rsp_ready = 1'b0;
    push_cmd(4'd1, 4'd2, 2'b00, 2'd0);
    push_cmd(4'd8, 4'd3, 2'b01, 2'd1);
    push_cmd(4'd4, 4'd4, 2'b10, 2'd2);
    push_cmd(4'd9, 4'd2, 2'b11, 2'd3);
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b1;
    cmd_a = 4'd6; cmd_b = 4'd7; cmd_sel = 2'b00; cmd_tag = 2'd0; cmd_valid = 1'b1;
    check("pp_ready_before", cmd_ready, 1);
    if (cmd_ready) exp_q.push_back(model(4'd6, 4'd7, 2'b00, 2'd0));
    @(posedge clk);
    #1 cmd_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    check("pp_count_kept", cmd_ready, 1);
    push_cmd(4'd11, 4'd3, 2'b01, 2'd1);
    @(negedge clk);
    check("pp_full_after", cmd_ready, 0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    // randomized traffic with random backpressure
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          push_cmd(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)), TAG_W'(n));
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1 rsp_ready = 1'b1;
    drain();

    // reset during WAIT with two commands queued
    push_cmd(4'd3, 4'd4, 2'b00, 2'd1);
    push_cmd(4'd9, 4'd1, 2'b01, 2'd2);
    push_cmd(4'd2, 4'd2, 2'b10, 2'd3);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_alu_rst", alu_rst, 1);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_rsp", rsp_valid, 0);
    check("midrst_idle_busy", busy, 0);
    push_cmd(4'd1, 4'd1, 2'b00, 2'd2);
    drain();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
